oen_clr_multi: RTL and testbench
================================

Name: oen_clr_multi

Overview:
- Parametrised, multi-channel successor to the single-channel output-enable clear controller in the CNN accelerator output path.
- Each channel watches one output-buffer full flag.
- After a programmable wait, the channel drops its clear so the buffer can drain, then re-arms when the flag falls.
- Adds an optional one-channel-at-a-time (serial) drain arbitration mode, per-channel done pulses, a busy flag and a flush counter for the Nios-side status registers.

Parameters:
CHANNELS, 4, number of independent output buffers controlled (>=1)
WAIT_CYCLES, 1, edges from sampled full to clear deassert (>=1; 0 is a synthesis-time error)
SERIAL, 0, 1 = at most one channel in ENABLE at a time (fixed priority, lowest index wins); 0 = channels independent
CNT_W, 16, width of completed-flush counter

Ports:
OEN_CLR_MULTI_Clk  in  1  clock; all logic on rising edge
OEN_CLR_MULTI_Reset  in  1  synchronous, active-high reset
OEN_CLR_MULTI_Flag_Out_Full  in  CHANNELS  per-channel buffer-full flag, level
OEN_CLR_MULTI_Clr  out  CHANNELS  per-channel output-enable clear (1 = held clear)
OEN_CLR_MULTI_Rptclr  out  CHANNELS  per-channel report-clear (1 = channel armed/idle)
OEN_CLR_MULTI_Done  out  CHANNELS  one-cycle pulse when a channel's drain completes
OEN_CLR_MULTI_Busy  out  1  OR of all channels not in ARMED
OEN_CLR_MULTI_Flush_Count  out  CNT_W  total completed drains, all channels

Behaviour:
- Reset is synchronous and active-high; the clock is OEN_CLR_MULTI_Clk and the reset is OEN_CLR_MULTI_Reset.
- Reset values: all states ARMED, Clr all 1, Rptclr all 1, Done 0, Busy 0, Flush_Count 0, wait counters 0. Reset asserted mid-operation overrides everything on that edge, including any in-progress WAIT, ENABLE or Done pulse.
- All outputs are registered; no combinational path from Flag_Out_Full to any output.
- Per-channel FSM: ARMED, WAIT, PEND, ENABLE.
- ARMED: Clr=1, Rptclr=1.
  - Full sampled 1 at edge k: go to WAIT, load counter with WAIT_CYCLES-1, Rptclr=0 after edge k.
- WAIT: Clr=1, Rptclr=0.
  - Full=0 at an edge: abort to ARMED (Rptclr=1, no Done, no count).
  - Counter>0: decrement.
  - Counter==0 with Full=1: go to ENABLE (Clr=0 after edge k+WAIT_CYCLES). If SERIAL=1 and the grant is not available, go to PEND instead.
- PEND (SERIAL=1 only): Clr=1, Rptclr=0.
  - Full=0: abort to ARMED.
  - Grant available: go to ENABLE.
- Grant rule (SERIAL=1): available on an edge when no channel is in ENABLE after that edge's updates, excluding a channel that is leaving ENABLE on the same edge. Among channels requesting on the same edge, the lowest index wins; losers stay in or enter PEND.
- ENABLE: Clr=0, Rptclr=0.
  - Stays while Full=1.
  - Full=0 at an edge: go to ARMED (Clr=1, Rptclr=1), Done[i]=1 for exactly that next cycle, Flush_Count increments.
- Flush_Count:
  - Adds the number of channels completing on an edge; several channels may complete simultaneously.
  - Wraps modulo 2^CNT_W without saturation.
- Full re-asserted on the edge immediately after ENABLE->ARMED: a normal new ARMED->WAIT transition; the Done pulse still occurs.
- SERIAL=0: channels fully independent. CHANNELS=1, WAIT_CYCLES=1, SERIAL=0 matches legacy single-channel timing (Clr falls 2 edges after Full rises, Rptclr falls 1 edge after).

Test Plan:
- Reset then idle, CHANNELS=4 -> Clr=4'hF, Rptclr=4'hF, Done=0, Busy=0, Flush_Count=0.
- WAIT_CYCLES=3, Full[0] high at edge 10, low at edge 20 -> Rptclr[0]=0 from edge 10; Clr[0]=0 from edge 13 through edge 19; Clr[0]=Rptclr[0]=1 and Done[0]=1 for one cycle after edge 20; Flush_Count=1.
- WAIT_CYCLES=3, Full[1] pulse high edges 5..6 only -> WAIT aborted, Clr[1] never 0, no Done, count unchanged, Busy high edges 5..6 only.
- SERIAL=1, Full[2] and Full[1] rise on the same edge -> ch1 enabled, ch2 in PEND with Clr[2]=1. Full[1] drops at edge n -> ch2 Clr=0 after edge n; Done[1] pulses.
- SERIAL=0, all four Full drop on the same edge after ENABLE -> Done=4'hF for one cycle; Flush_Count +4. With CNT_W=2 starting at 3, it reads 3 (wrap).
- Reset asserted while ch0 is in ENABLE and ch3 is in WAIT -> next cycle all ARMED, Clr=4'hF, Done=0, Flush_Count=0.

Source files
------------

// File: rtl/oen_clr_multi.sv
// Multi-channel output-enable clear controller: each channel holds its buffer
// clear until the full flag has been seen for WAIT_CYCLES edges, then releases it until the flag falls.
module oen_clr_multi #(
  parameter int CHANNELS    = 4,
  parameter int WAIT_CYCLES = 1,
  parameter bit SERIAL      = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic                OEN_CLR_MULTI_Clk,
  input  logic                OEN_CLR_MULTI_Reset,
  input  logic [CHANNELS-1:0] OEN_CLR_MULTI_Flag_Out_Full,
  output logic [CHANNELS-1:0] OEN_CLR_MULTI_Clr,
  output logic [CHANNELS-1:0] OEN_CLR_MULTI_Rptclr,
  output logic [CHANNELS-1:0] OEN_CLR_MULTI_Done,
  output logic                OEN_CLR_MULTI_Busy,
  output logic [CNT_W-1:0]    OEN_CLR_MULTI_Flush_Count
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1) begin : g_bad_wait
      $error("oen_clr_multi: WAIT_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_PEND   = 2'd2,
    ST_ENABLE = 2'd3
  } state_t;

  state_t              r_state     [CHANNELS];
  state_t              w_state_nxt [CHANNELS];
  logic [CW-1:0]       r_cnt       [CHANNELS];
  logic [CW-1:0]       w_cnt_nxt   [CHANNELS];
  logic [CHANNELS-1:0] w_req;
  logic [CHANNELS-1:0] w_stay;
  logic [CHANNELS-1:0] w_done;
  logic [CHANNELS-1:0] w_enable_nxt;
  logic [CHANNELS-1:0] w_armed_nxt;
  logic                w_grant_taken;

  function automatic logic [CNT_W-1:0] f_popcount(input logic [CHANNELS-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s = s + CNT_W'(v[i]);
    end
    return s;
  endfunction

  // Per-channel next state, then serial-mode grant resolution (lowest index wins)
  always_comb begin
    w_req         = '0;
    w_stay        = '0;
    w_done        = '0;
    w_grant_taken = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_ARMED: begin
          if (OEN_CLR_MULTI_Flag_Out_Full[i]) begin
            w_state_nxt[i] = ST_WAIT;
            w_cnt_nxt[i]   = CNT_LOAD;
          end else begin
            w_state_nxt[i] = ST_ARMED;
          end
        end
        ST_WAIT: begin
          if (!OEN_CLR_MULTI_Flag_Out_Full[i]) begin
            w_state_nxt[i] = ST_ARMED;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] != '0) begin
            w_cnt_nxt[i]   = r_cnt[i] - CW'(1);
          end else begin
            w_req[i]       = 1'b1;
          end
        end
        ST_PEND: begin
          if (!OEN_CLR_MULTI_Flag_Out_Full[i]) begin
            w_state_nxt[i] = ST_ARMED;
          end else begin
            w_req[i]       = 1'b1;
          end
        end
        ST_ENABLE: begin
          if (!OEN_CLR_MULTI_Flag_Out_Full[i]) begin
            w_state_nxt[i] = ST_ARMED;
            w_done[i]      = 1'b1;
          end else begin
            w_stay[i]      = 1'b1;
          end
        end
        default: begin
          w_state_nxt[i] = ST_ARMED;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end

    // A channel leaving ENABLE on this edge does not block the grant
    w_grant_taken = SERIAL && (|w_stay);
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_req[i]) begin
        if (!SERIAL) begin
          w_state_nxt[i] = ST_ENABLE;
        end else if (!w_grant_taken) begin
          w_state_nxt[i] = ST_ENABLE;
          w_grant_taken  = 1'b1;
        end else begin
          w_state_nxt[i] = ST_PEND;
        end
      end else begin
        w_state_nxt[i] = w_state_nxt[i];
      end
    end

    for (int i = 0; i < CHANNELS; i++) begin
      w_enable_nxt[i] = (w_state_nxt[i] == ST_ENABLE);
      w_armed_nxt[i]  = (w_state_nxt[i] == ST_ARMED);
    end
  end

  // State, counters and registered status outputs
  always_ff @(posedge OEN_CLR_MULTI_Clk) begin
    if (OEN_CLR_MULTI_Reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= ST_ARMED;
        r_cnt[i]   <= '0;
      end
      OEN_CLR_MULTI_Clr         <= '1;
      OEN_CLR_MULTI_Rptclr      <= '1;
      OEN_CLR_MULTI_Done        <= '0;
      OEN_CLR_MULTI_Busy        <= 1'b0;
      OEN_CLR_MULTI_Flush_Count <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      OEN_CLR_MULTI_Clr         <= ~w_enable_nxt;
      OEN_CLR_MULTI_Rptclr      <= w_armed_nxt;
      OEN_CLR_MULTI_Done        <= w_done;
      OEN_CLR_MULTI_Busy        <= ~(&w_armed_nxt);
      OEN_CLR_MULTI_Flush_Count <= OEN_CLR_MULTI_Flush_Count + f_popcount(w_done);
    end
  end

endmodule

// File: tb/tb_oen_clr_multi.sv
// Bench for oen_clr_multi: an independent (A, CNT_W=2) and a serial (B) instance,
// each checked every cycle against a behavioural model plus hand-computed pins.
module tb_oen_clr_multi;

  localparam int WC = 3;
  localparam int M_ARM = 0, M_WT = 1, M_PD = 2, M_EN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fa, fb;
  logic [3:0] clr_a, rpt_a, done_a, clr_b, rpt_b, done_b;
  logic       busy_a, busy_b;
  logic [1:0] cnt_a;
  logic [15:0] cnt_b;

  int checks = 0;
  int errors = 0;

  int       mst  [2][4];
  int       mleft[2][4];
  int       mcnt [2];
  logic [3:0] mdone[2];
  bit       mvalid = 1'b0;

  always #5 clk = ~clk;

  oen_clr_multi #(.CHANNELS(4), .WAIT_CYCLES(WC), .SERIAL(1'b0), .CNT_W(2)) u_a (
    .OEN_CLR_MULTI_Clk(clk), .OEN_CLR_MULTI_Reset(rst), .OEN_CLR_MULTI_Flag_Out_Full(fa),
    .OEN_CLR_MULTI_Clr(clr_a), .OEN_CLR_MULTI_Rptclr(rpt_a), .OEN_CLR_MULTI_Done(done_a),
    .OEN_CLR_MULTI_Busy(busy_a), .OEN_CLR_MULTI_Flush_Count(cnt_a));

  oen_clr_multi #(.CHANNELS(4), .WAIT_CYCLES(WC), .SERIAL(1'b1), .CNT_W(16)) u_b (
    .OEN_CLR_MULTI_Clk(clk), .OEN_CLR_MULTI_Reset(rst), .OEN_CLR_MULTI_Flag_Out_Full(fb),
    .OEN_CLR_MULTI_Clr(clr_b), .OEN_CLR_MULTI_Rptclr(rpt_b), .OEN_CLR_MULTI_Done(done_b),
    .OEN_CLR_MULTI_Busy(busy_b), .OEN_CLR_MULTI_Flush_Count(cnt_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel's progress through the drain sequence, one edge at a time
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [3:0] f;
      bit         ser, busy_en;
      bit         want[4];
      f   = (m == 0) ? fa : fb;
      ser = (m == 1);
      busy_en = 1'b0;
      mdone[m] = 4'b0000;
      if (rst) begin
        for (int c = 0; c < 4; c++) begin
          mst[m][c] = M_ARM;
          mleft[m][c] = 0;
        end
        mcnt[m] = 0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          want[c] = 1'b0;
          if (!f[c]) begin
            if (mst[m][c] == M_EN) begin
              mdone[m][c] = 1'b1;
              mcnt[m]++;
            end
            mst[m][c] = M_ARM;
          end else if (mst[m][c] == M_ARM) begin
            mst[m][c] = M_WT;
            mleft[m][c] = WC - 1;
          end else if (mst[m][c] == M_WT && mleft[m][c] > 0) begin
            mleft[m][c]--;
          end else if (mst[m][c] == M_EN) begin
            busy_en = 1'b1;
          end else begin
            want[c] = 1'b1;
          end
        end
        for (int c = 0; c < 4; c++) begin
          if (want[c]) begin
            if (!ser || !busy_en) begin
              mst[m][c] = M_EN;
              busy_en = ser;
            end else begin
              mst[m][c] = M_PD;
            end
          end
        end
      end
    end
    mvalid <= 1'b1;
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (mvalid) begin
      for (int m = 0; m < 2; m++) begin
        logic [3:0] eclr, erpt;
        for (int c = 0; c < 4; c++) begin
          eclr[c] = (mst[m][c] != M_EN);
          erpt[c] = (mst[m][c] == M_ARM);
        end
        if (m == 0) begin
          chk("a_clr", {28'd0, clr_a}, {28'd0, eclr});
          chk("a_rptclr", {28'd0, rpt_a}, {28'd0, erpt});
          chk("a_done", {28'd0, done_a}, {28'd0, mdone[0]});
          chk("a_busy", {31'd0, busy_a}, {31'd0, ~(&erpt)});
          chk("a_count", {30'd0, cnt_a}, 32'(mcnt[0] % 4));
        end else begin
          chk("b_clr", {28'd0, clr_b}, {28'd0, eclr});
          chk("b_rptclr", {28'd0, rpt_b}, {28'd0, erpt});
          chk("b_done", {28'd0, done_b}, {28'd0, mdone[1]});
          chk("b_busy", {31'd0, busy_b}, {31'd0, ~(&erpt)});
          chk("b_count", {16'd0, cnt_b}, 32'(mcnt[1] % 65536));
        end
      end
    end
  end

  task automatic run(input int n, input logic [3:0] a, input logic [3:0] b);
    fa = a;
    fb = b;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    fa  = 4'h0;
    fb  = 4'h0;
    run(2, 4'h0, 4'h0);
    rst = 1'b0;
    run(2, 4'h0, 4'h0);
    chk("pin_reset_clr", {28'd0, clr_a}, 32'h0000000F);
    chk("pin_reset_rpt", {28'd0, rpt_a}, 32'h0000000F);
    chk("pin_reset_done", {28'd0, done_a}, 32'h00000000);
    chk("pin_reset_busy", {31'd0, busy_a}, 32'h00000000);
    chk("pin_reset_cnt", {30'd0, cnt_a}, 32'h00000000);

    // ch0 full for 10 edges: clear holds through the third edge, drops on the fourth
    run(3, 4'b0001, 4'h0);
    chk("pin_wait_clr0", {31'd0, clr_a[0]}, 32'd1);
    chk("pin_wait_rpt0", {31'd0, rpt_a[0]}, 32'd0);
    run(7, 4'b0001, 4'h0);
    chk("pin_en_clr0", {31'd0, clr_a[0]}, 32'd0);
    run(1, 4'b0000, 4'h0);
    chk("pin_done0", {28'd0, done_a}, 32'h00000001);
    chk("pin_cnt1", {30'd0, cnt_a}, 32'd1);
    run(1, 4'b0000, 4'h0);
    chk("pin_done0_off", {28'd0, done_a}, 32'h00000000);

    // ch1 two-edge pulse aborts in WAIT
    run(2, 4'b0010, 4'h0);
    chk("pin_abort_busy", {31'd0, busy_a}, 32'd1);
    run(1, 4'b0000, 4'h0);
    chk("pin_abort_idle", {31'd0, busy_a}, 32'd0);
    chk("pin_abort_cnt", {30'd0, cnt_a}, 32'd1);

    // two drains on one edge, then four more: 1+2+4 = 7 wraps to 3
    run(6, 4'b0011, 4'h0);
    run(1, 4'b0000, 4'h0);
    chk("pin_cnt3", {30'd0, cnt_a}, 32'd3);
    run(5, 4'b1111, 4'h0);
    chk("pin_all_en", {28'd0, clr_a}, 32'h00000000);
    run(1, 4'b0000, 4'h0);
    chk("pin_done_all", {28'd0, done_a}, 32'h0000000F);
    chk("pin_wrap", {30'd0, cnt_a}, 32'd3);
    run(1, 4'b0000, 4'h0);

    // serial: ch1 and ch2 together, ch1 wins, ch2 takes over as ch1 drops
    run(4, 4'h0, 4'b0110);
    chk("pin_ser_clr", {28'd0, clr_b}, 32'h0000000D);
    chk("pin_ser_rpt", {28'd0, rpt_b}, 32'h00000009);
    run(2, 4'h0, 4'b0110);
    run(1, 4'h0, 4'b0100);
    chk("pin_ser_done1", {28'd0, done_b}, 32'h00000002);
    chk("pin_ser_hand", {28'd0, clr_b}, 32'h0000000B);
    run(1, 4'h0, 4'b0000);
    chk("pin_ser_cnt", {16'd0, cnt_b}, 32'd2);

    // reset with ch0 in ENABLE and ch3 in WAIT
    run(5, 4'b0001, 4'b0001);
    run(1, 4'b1001, 4'b0001);
    chk("pin_pre_rst", {28'd0, clr_a}, 32'h0000000E);
    rst = 1'b1;
    run(1, 4'b1001, 4'b0001);
    chk("pin_rst_clr", {28'd0, clr_a}, 32'h0000000F);
    chk("pin_rst_cnt", {30'd0, cnt_a}, 32'd0);
    chk("pin_rst_busy", {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    run(3, 4'b0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
